l2_cache: RTL and testbench

//  Shared direct-mapped L2 that sits directly below the coherence bus and serves its L2 request channel.

---
 rtl/cache_pkg.sv | 78 +++++++
 rtl/l2_line_array.sv | 34 +++
 rtl/l2_cache.sv | 235 +++++++++++++++++++++++
 tb/tb_l2_cache.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache types and widths for the coherence bus / L2 slice.
// Width macros L2_TAG_BITS, L2_INDEX_BITS and CACHELINE_BITS may be overridden on the command line.
`ifndef L2_TAG_BITS
`define L2_TAG_BITS 2
`endif
`ifndef L2_INDEX_BITS
`define L2_INDEX_BITS 4
`endif
`ifndef CACHELINE_BITS
`define CACHELINE_BITS 1
`endif

package cache_pkg;

  localparam int unsigned TAG_BITS       = `L2_TAG_BITS;
  localparam int unsigned INDEX_BITS     = `L2_INDEX_BITS;
  localparam int unsigned OFFSET_BITS    = 0;
  localparam int unsigned CACHELINE_BITS = `CACHELINE_BITS;
  localparam int unsigned ADDR_BITS      = TAG_BITS + INDEX_BITS + OFFSET_BITS;

  // L1 coherence states
  typedef enum logic [2:0] {
    MOESI_I = 3'd0,
    MOESI_S = 3'd1,
    MOESI_E = 3'd2,
    MOESI_O = 3'd3,
    MOESI_M = 3'd4
  } moesi_t;

  typedef struct packed {
    moesi_t                    state;
    logic [TAG_BITS-1:0]       tag;
    logic [CACHELINE_BITS-1:0] data;
  } l1_cacheline_t;

  // L2 line states; L2_I must encode as zero so a cleared line reads invalid
  typedef enum logic [1:0] {
    L2_I = 2'd0,
    L2_C = 2'd1,
    L2_D = 2'd2
  } l2_state_t;

  typedef struct packed {
    l2_state_t                 state;
    logic [TAG_BITS-1:0]       tag;
    logic [CACHELINE_BITS-1:0] data;
  } l2_cacheline_t;

  // Coherence bus request kinds
  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_req_t;

  // L2 controller states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    EVICT     = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4,
    RESP      = 3'd5
  } l2_fsm_t;

  // Build an L2 line from its fields
  function automatic l2_cacheline_t make_l2_line(input l2_state_t               st,
                                                 input logic [TAG_BITS-1:0]       tag,
                                                 input logic [CACHELINE_BITS-1:0] data);
    l2_cacheline_t l;
    l.state = st;
    l.tag   = tag;
    l.data  = data;
    return l;
  endfunction

endpackage

// File: rtl/l2_line_array.sv
// Direct-mapped L2 line storage: one combinational read port, one write port,
// every line invalidated by the asynchronous reset.
module l2_line_array
  import cache_pkg::*;
#(
  parameter int unsigned IDX_W = INDEX_BITS
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output l2_cacheline_t rd_line_o,
  input  logic          wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  l2_cacheline_t wr_line_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  l2_cacheline_t lines_q [DEPTH];

  // Line write, with reset forcing every line to L2_I
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        lines_q[i] <= make_l2_line(L2_I, '0, '0);
      end
    end else if (wr_en_i) begin
      lines_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_line_o = lines_q[rd_idx_i];

endmodule

// File: rtl/l2_cache.sv
// Shared direct-mapped write-back, write-allocate L2 below the coherence bus.
// Serves line reads and writebacks; one outstanding request to main memory.
// Optional macro L2_STATS_EN adds saturating hit/miss/evict counters.
module l2_cache
  import cache_pkg::*;
#(
  parameter int unsigned TAG_W  = TAG_BITS,
  parameter int unsigned IDX_W  = INDEX_BITS,
  parameter int unsigned LINE_W = CACHELINE_BITS
`ifdef L2_STATS_EN
  ,
  parameter int unsigned STAT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   l2_req_valid,
  output logic                   l2_req_ready,
  input  logic [TAG_W+IDX_W-1:0] l2_req_addr,
  input  logic                   l2_req_rw,
  input  logic [LINE_W-1:0]      l2_req_data,
  output logic                   l2_resp_valid,
  output logic [LINE_W-1:0]      l2_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [TAG_W+IDX_W-1:0] mem_req_addr,
  output logic                   mem_req_rw,
  output logic [LINE_W-1:0]      mem_req_data,
  input  logic                   mem_resp_valid,
  input  logic [LINE_W-1:0]      mem_resp_data
`ifdef L2_STATS_EN
  ,
  output logic [STAT_W-1:0]      l2_hit_cnt,
  output logic [STAT_W-1:0]      l2_miss_cnt,
  output logic [STAT_W-1:0]      l2_evict_cnt
`endif
);

  localparam int unsigned ADDR_W = TAG_W + IDX_W;

  l2_fsm_t           state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [LINE_W-1:0] wdata_q;

  logic              ready_q;
  logic              resp_valid_q;
  logic [LINE_W-1:0] resp_data_q;
  logic              mreq_valid_q;
  logic [ADDR_W-1:0] mreq_addr_q;
  logic              mreq_rw_q;
  logic [LINE_W-1:0] mreq_data_q;

  logic [IDX_W-1:0]  idx_c;
  logic [TAG_W-1:0]  tag_c;
  l2_cacheline_t     rd_line_c;
  logic              hit_c;
  logic              victim_dirty_c;
  logic              wr_en_c;
  l2_cacheline_t     wr_line_c;

  assign idx_c          = addr_q[IDX_W-1:0];
  assign tag_c          = addr_q[ADDR_W-1:IDX_W];
  assign hit_c          = (rd_line_c.state != L2_I) && (rd_line_c.tag == tag_c);
  assign victim_dirty_c = (rd_line_c.state == L2_D);

  l2_line_array #(
    .IDX_W (IDX_W)
  ) u_lines (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_idx_i  (idx_c),
    .rd_line_o (rd_line_c),
    .wr_en_i   (wr_en_c),
    .wr_idx_i  (idx_c),
    .wr_line_i (wr_line_c)
  );

  // Line install: write hit / clean write miss, write after eviction, or fill
  always_comb begin
    wr_en_c   = 1'b0;
    wr_line_c = make_l2_line(L2_I, '0, '0);
    case (state_q)
      LOOKUP: begin
        if (rw_q && (hit_c || !victim_dirty_c)) begin
          wr_en_c   = 1'b1;
          wr_line_c = make_l2_line(L2_D, tag_c, wdata_q);
        end
      end
      EVICT: begin
        if (mem_req_ready && rw_q) begin
          wr_en_c   = 1'b1;
          wr_line_c = make_l2_line(L2_D, tag_c, wdata_q);
        end
      end
      FILL_WAIT: begin
        if (mem_resp_valid) begin
          wr_en_c   = 1'b1;
          wr_line_c = make_l2_line(L2_C, tag_c, mem_resp_data);
        end
      end
      default: ;
    endcase
  end

  // Controller FSM with registered bus and memory outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      mreq_valid_q <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_rw_q    <= 1'b0;
      mreq_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (l2_req_valid && ready_q) begin
            addr_q  <= l2_req_addr;
            rw_q    <= l2_req_rw;
            wdata_q <= l2_req_data;
            ready_q <= 1'b0;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_c) begin
            if (!rw_q) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= rd_line_c.data;
              state_q      <= RESP;
            end else begin
              ready_q <= 1'b1;
              state_q <= IDLE;
            end
          end else if (victim_dirty_c) begin
            mreq_valid_q <= 1'b1;
            mreq_rw_q    <= 1'b1;
            mreq_addr_q  <= {rd_line_c.tag, idx_c};
            mreq_data_q  <= rd_line_c.data;
            state_q      <= EVICT;
          end else if (!rw_q) begin
            mreq_valid_q <= 1'b1;
            mreq_rw_q    <= 1'b0;
            mreq_addr_q  <= addr_q;
            mreq_data_q  <= '0;
            state_q      <= FILL_REQ;
          end else begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        EVICT: begin
          if (mem_req_ready) begin
            if (!rw_q) begin
              mreq_rw_q   <= 1'b0;
              mreq_addr_q <= addr_q;
              mreq_data_q <= '0;
              state_q     <= FILL_REQ;
            end else begin
              mreq_valid_q <= 1'b0;
              ready_q      <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            mreq_valid_q <= 1'b0;
            state_q      <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          if (mem_resp_valid) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= mem_resp_data;
            state_q      <= RESP;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign l2_req_ready  = ready_q;
  assign l2_resp_valid = resp_valid_q;
  assign l2_resp_data  = resp_data_q;
  assign mem_req_valid = mreq_valid_q;
  assign mem_req_addr  = mreq_addr_q;
  assign mem_req_rw    = mreq_rw_q;
  assign mem_req_data  = mreq_data_q;

`ifdef L2_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q;
  logic [STAT_W-1:0] miss_cnt_q;
  logic [STAT_W-1:0] evict_cnt_q;

  // Saturating lookup and eviction counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      evict_cnt_q <= '0;
    end else begin
      if (state_q == LOOKUP) begin
        if (hit_c) begin
          if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + STAT_W'(1);
        end else begin
          if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + STAT_W'(1);
        end
      end
      if ((state_q == EVICT) && mem_req_ready && (evict_cnt_q != '1)) begin
        evict_cnt_q <= evict_cnt_q + STAT_W'(1);
      end
    end
  end

  assign l2_hit_cnt   = hit_cnt_q;
  assign l2_miss_cnt  = miss_cnt_q;
  assign l2_evict_cnt = evict_cnt_q;
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Scoreboard bench for l2_cache: a set-array reference model predicts memory
// traffic and read responses; monitors compare them as the DUT produces them.
module tb_l2_cache;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          l2_req_valid;
  logic          l2_req_ready;
  logic [AW-1:0] l2_req_addr;
  logic          l2_req_rw;
  logic          l2_req_data;
  logic          l2_resp_valid;
  logic          l2_resp_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_rw;
  logic          mem_req_data;
  logic          mem_resp_valid;
  logic          mem_resp_data;
`ifdef L2_STATS_EN
  logic [15:0]   l2_hit_cnt;
  logic [15:0]   l2_miss_cnt;
  logic [15:0]   l2_evict_cnt;
`endif

  l2_cache dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .l2_req_valid   (l2_req_valid),
    .l2_req_ready   (l2_req_ready),
    .l2_req_addr    (l2_req_addr),
    .l2_req_rw      (l2_req_rw),
    .l2_req_data    (l2_req_data),
    .l2_resp_valid  (l2_resp_valid),
    .l2_resp_data   (l2_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_rw     (mem_req_rw),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef L2_STATS_EN
    ,
    .l2_hit_cnt     (l2_hit_cnt),
    .l2_miss_cnt    (l2_miss_cnt),
    .l2_evict_cnt   (l2_evict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bound_fail(input string name, input int waited, input int limit);
    n_checks++;
    $display("FAIL %s: still waiting after %0d cycles, required within %0d", name, waited, limit);
  endtask

  // Expected traffic
  typedef struct { logic rw; logic [AW-1:0] addr; logic data; } mreq_t;
  typedef struct { logic data; int edge_at; } resp_t;
  mreq_t exp_mem[$];
  resp_t exp_resp[$];

  // Reference model: per-set valid/dirty/tag/data plus a backing memory image
  bit       m_valid [16];
  bit       m_dirty [16];
  logic [1:0] m_tag [16];
  logic     m_data  [16];
  logic     ref_mem [64];
  int       m_hits, m_misses, m_evicts;

  // Memory responder state
  logic     mem [64];
  bit       fill_pend    = 0;
  logic [AW-1:0] fill_addr;
  int       fill_delay   = 0;
  bit       force_low    = 0;
  bit       hold_resp    = 0;
  bit       stray_force  = 0;
  int       last_resp_edge = -1;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = 1'b0;
    end
    m_hits = 0; m_misses = 0; m_evicts = 0;
  endtask

  task automatic model_access(input logic [AW-1:0] a, input logic rw, input logic d,
                              input int acc_edge, output bit quick);
    int ix;
    logic [1:0] tg;
    logic [AW-1:0] va;
    ix = int'(a[3:0]);
    tg = a[5:4];
    quick = 0;
    if (m_valid[ix] && m_tag[ix] == tg) begin
      m_hits++;
      if (!rw) exp_resp.push_back('{m_data[ix], acc_edge + 2});
      else begin m_dirty[ix] = 1; m_data[ix] = d; quick = 1; end
    end else begin
      m_misses++;
      if (m_valid[ix] && m_dirty[ix]) begin
        m_evicts++;
        va = {m_tag[ix], 4'(ix)};
        exp_mem.push_back('{1'b1, va, m_data[ix]});
        ref_mem[va] = m_data[ix];
      end else if (rw) begin
        quick = 1;
      end
      m_valid[ix] = 1;
      m_tag[ix]   = tg;
      if (!rw) begin
        exp_mem.push_back('{1'b0, a, 1'b0});
        m_dirty[ix] = 0;
        m_data[ix]  = ref_mem[a];
        exp_resp.push_back('{ref_mem[a], -1});
      end else begin
        m_dirty[ix] = 1;
        m_data[ix]  = d;
      end
    end
  endtask

  // Present one request, hold valid until accepted, update the model on accept
  task automatic issue(input logic [AW-1:0] a, input logic rw, input logic d, output int acc_edge);
    bit quick;
    bit ok;
    int waitc;
    ok = 0; waitc = 0; quick = 0;
    @(posedge clk); #1;
    l2_req_valid = 1'b1; l2_req_addr = a; l2_req_rw = rw; l2_req_data = d;
    while (!ok && waitc < 300) begin
      @(negedge clk);
      if (l2_req_ready) ok = 1; else waitc++;
    end
    acc_edge = cyc + 1;
    if (!ok) bound_fail("accept", waitc, 300);
    else model_access(a, rw, d, acc_edge, quick);
    @(posedge clk); #1;
    l2_req_valid = 1'b0;
    if (ok && quick) begin
      @(negedge clk); check("wr_ready_t1", 32'(l2_req_ready), 32'd0);
      @(negedge clk); check("wr_ready_t2", 32'(l2_req_ready), 32'd1);
    end
  endtask

  // Wait for all expected traffic to be seen and the cache to be idle
  task automatic drain();
    int waitc;
    waitc = 0;
    while ((exp_resp.size() != 0 || exp_mem.size() != 0 || !l2_req_ready) && waitc < 300) begin
      @(negedge clk); waitc++;
    end
    if (waitc >= 300) bound_fail("drain", waitc, 300);
  endtask

  // Memory side: random ready, fill responses after a random delay, stray response pulses
  initial begin
    bit hs; logic hs_rw; logic [AW-1:0] hs_addr; logic hs_data;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 1'b0;
    forever begin
      @(negedge clk);
      hs = reset_n && mem_req_valid && mem_req_ready;
      hs_rw = mem_req_rw; hs_addr = mem_req_addr; hs_data = mem_req_data;
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (!reset_n) begin
        fill_pend = 0;
      end else if (hs) begin
        if (hs_rw) mem[hs_addr] = hs_data;
        else begin fill_pend = 1; fill_addr = hs_addr; fill_delay = int'($urandom_range(0, 3)); end
      end
      if (fill_pend && !hold_resp && reset_n) begin
        if (fill_delay == 0) begin
          mem_resp_valid = 1'b1; mem_resp_data = mem[fill_addr]; fill_pend = 0;
        end else fill_delay--;
      end else if (!fill_pend && (stray_force || $urandom_range(0, 9) == 0)) begin
        mem_resp_valid = 1'b1; mem_resp_data = 1'($urandom);
      end
      mem_req_ready = force_low ? 1'b0 : ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: read responses, memory handshakes and request stability
  initial begin
    resp_t er; mreq_t em;
    bit stall; logic [AW-1:0] s_addr; logic s_rw; logic s_data;
    stall = 0; s_addr = '0; s_rw = 1'b0; s_data = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && l2_resp_valid) begin
        last_resp_edge = cyc + 1;
        if (exp_resp.size() == 0) check("unexpected_resp", 32'(l2_resp_valid), 32'd0);
        else begin
          er = exp_resp.pop_front();
          check("resp_data", 32'(l2_resp_data), 32'(er.data));
          if (er.edge_at >= 0) check("hit_latency", 32'(cyc + 1), 32'(er.edge_at));
        end
      end
      if (reset_n && mem_req_valid && mem_req_ready) begin
        if (exp_mem.size() == 0) check("unexpected_mem_req", 32'(mem_req_valid), 32'd0);
        else begin
          em = exp_mem.pop_front();
          check("mem_rw", 32'(mem_req_rw), 32'(em.rw));
          check("mem_addr", 32'(mem_req_addr), 32'(em.addr));
          if (em.rw) check("mem_wdata", 32'(mem_req_data), 32'(em.data));
        end
      end
      if (!reset_n) stall = 0;
      else begin
        if (stall) begin
          check("stall_valid", 32'(mem_req_valid), 32'd1);
          check("stall_payload", {24'd0, mem_req_addr, mem_req_rw, mem_req_data},
                {24'd0, s_addr, s_rw, s_data});
        end
        stall = mem_req_valid && !mem_req_ready;
        s_addr = mem_req_addr; s_rw = mem_req_rw; s_data = mem_req_data;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(l2_req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(l2_resp_valid), 32'd0);
    check({tag, "_resp_data"}, 32'(l2_resp_data), 32'd0);
    check({tag, "_mem_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_mem_addr_rw_data"}, {24'd0, mem_req_addr, mem_req_rw, mem_req_data}, 32'd0);
`ifdef L2_STATS_EN
    check({tag, "_cnts"}, {l2_hit_cnt, l2_miss_cnt ^ l2_evict_cnt}, 32'd0);
    check({tag, "_evict_cnt"}, 32'(l2_evict_cnt), 32'd0);
`endif
  endtask

  // Directed scenarios followed by a randomized stream
  initial begin
    int e1, e2, waitc;
    logic [AW-1:0] a;
    reset_n = 1'b0;
    l2_req_valid = 1'b0; l2_req_addr = '0; l2_req_rw = 1'b0; l2_req_data = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 1'($urandom); ref_mem[i] = mem[i];
    end
    mem[5] = 1'b1; ref_mem[5] = 1'b1;
    model_clear();
    #12;
    check_reset_outputs("rst0");
    @(negedge clk); reset_n = 1'b1;

    // Read miss fill, then read hit with fixed latency
    issue(6'h05, 1'b0, 1'b0, e1); drain();
    issue(6'h05, 1'b0, 1'b0, e1); drain();
    // Write to same set, other tag: clean victim, no memory traffic
    issue(6'h15, 1'b1, 1'b0, e1); drain();

    // Dirty victim eviction with memory held off
    force_low = 1;
    issue(6'h25, 1'b0, 1'b0, e1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_req_ready", 32'(l2_req_ready), 32'd0);
      check("hold_mem_valid", 32'(mem_req_valid), 32'd1);
      check("hold_mem_evict", {24'd0, mem_req_addr, mem_req_rw, mem_req_data}, {24'd0, 6'h15, 1'b1, 1'b0});
    end
    force_low = 0;
    drain();

    // Stray memory responses in idle, then back-to-back requests held off while busy
    stray_force = 1;
    repeat (3) @(negedge clk);
    stray_force = 0;
    issue(6'h33, 1'b0, 1'b0, e1);
    issue(6'h25, 1'b0, 1'b0, e2);
    check("held_off_until_resp", 32'((e2 > last_resp_edge) && (last_resp_edge > e1)), 32'd1);
    drain();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      issue(6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom), e1);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    // Reset while waiting on a fill
    do a = 6'($urandom_range(0, 63));
    while (m_valid[int'(a[3:0])] && m_tag[int'(a[3:0])] == a[5:4]);
    hold_resp = 1;
    issue(a, 1'b0, 1'b0, e1);
    waitc = 0;
    while (!fill_pend && waitc < 200) begin @(negedge clk); waitc++; end
    if (!fill_pend) bound_fail("fill_handshake", waitc, 200);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst1");
    exp_resp.delete(); exp_mem.delete();
    model_clear();
    hold_resp = 0;
    repeat (2) @(negedge clk);
    check("rst1_no_resp", 32'(l2_resp_valid), 32'd0);
    reset_n = 1'b1;
    issue(a, 1'b0, 1'b0, e1);
    check("rst1_refetch_expected", 32'(exp_mem.size()), 32'd1);
    drain();

    check("exp_resp_empty", 32'(exp_resp.size()), 32'd0);
    check("exp_mem_empty", 32'(exp_mem.size()), 32'd0);
`ifdef L2_STATS_EN
    check("stat_hits", 32'(l2_hit_cnt), 32'(m_hits));
    check("stat_misses", 32'(l2_miss_cnt), 32'(m_misses));
    check("stat_evicts", 32'(l2_evict_cnt), 32'(m_evicts));
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #600000;
    bound_fail("global_timeout", cyc, 60000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
